seg_code_decoder: RTL
=====================

SEG_CODE_DECODER -- requirements
Module: seg_code_decoder

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO depth in entries; legal values 2, 4, 8, 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  in_code is presented this cycle.
REQ-005 in_code  input  4  encoded code word to decode.
REQ-006 in_ready  output  1  block accepts in_code this cycle.
REQ-007 out_valid  output  1  FIFO head entry valid on out_data/out_err.
REQ-008 out_data  output  8  decoded one-hot word at FIFO head.
REQ-009 out_err  output  1  FIFO head entry came from an illegal code.
REQ-010 out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 clear_err  input  1  clears err_count.
REQ-012 err_count  output  8  saturating count of illegal codes accepted.
REQ-013 fill  output  5  current FIFO occupancy, 0..DEPTH.

Function
REQ-014 Input transfer occurs only on a cycle where in_valid=1 and in_ready=1; output transfer occurs only where out_valid=1 and out_ready=1.
REQ-015 in_ready SHALL be 1 when fill<DEPTH, or when fill==DEPTH and an output transfer occurs in the same cycle (push-through when full).
REQ-016 out_valid SHALL be 1 exactly when fill>0; out_data/out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 Decode map, code -> out_data: 0000->8'h80, 0100->8'h40, 0001->8'h20, 0101->8'h10, 0011->8'h08, 0111->8'h04, 0010->8'h02, 0110->8'h01; out_err=0 for these codes.
REQ-018 Any code with in_code[3]=1 is illegal: stored entry is out_data=8'h00, out_err=1.
REQ-019 Latency: a code accepted at edge N into an empty FIFO SHALL appear on out_valid/out_data after edge N, that is, in cycle N+1; there is no combinational in->out path.
REQ-020 Entries SHALL leave in acceptance order; no entry is dropped or duplicated.
REQ-021 fill SHALL change by +1 on push only, by -1 on pop only, and by 0 on simultaneous push and pop, including at fill==DEPTH and at fill==1.
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
REQ-023 err_count SHALL increment by 1 on each accepted illegal code and saturate at 255.
REQ-024 clear_err=1 SHALL set err_count to 0 on the next edge; it takes priority over a same-cycle increment.
REQ-025 Illegal codes SHALL NOT stall the interface; they consume a FIFO entry like legal codes.
REQ-026 A pop SHALL NOT be possible when fill==0; a push SHALL NOT be possible when fill==DEPTH without a same-cycle pop.

Reset
REQ-027 While rst=1 at a rising edge: fill=0, pointers=0, err_count=0, out_valid=0, out_data=8'h00, out_err=0.
REQ-028 rst SHALL override all same-cycle transfers; entries present before reset are discarded, and in_valid during reset is not accepted.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 Reset, then push all 8 legal codes with out_ready=1 -> out_data sequence 80,40,20,10,08,04,02,01, each one cycle after its push, out_err=0, err_count=0.
REQ-031 Push codes 1000 and 1111 -> two entries with out_data=00, out_err=1; err_count=2.
REQ-032 out_ready=0, push DEPTH codes -> fill=DEPTH, in_ready=0; then out_ready=1 with in_valid=1 -> push-through, fill stays DEPTH, order preserved across pointer wrap.
REQ-033 Push 300 illegal codes -> err_count=255; then clear_err=1 in the same cycle as another illegal push -> err_count=0.
REQ-034 Fill FIFO to 3 entries, assert rst for one cycle alongside in_valid=1 -> fill=0, out_valid=0, err_count=0; the first subsequent push is output correctly.
REQ-035 Random valid/ready stalls over 10k codes against a scoreboard -> output stream equals input stream decoded per REQ-017/018, and err_count matches the model.

Source files
------------

// File: rtl/seg_code_decoder.sv
// 4-bit code to one-hot decoder feeding a DEPTH-entry result FIFO, with a
// saturating count of illegal codes. A decode failure is stored as data 8'h00 with the error flag set.

module seg_code_decoder #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_code,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_err,
  input  logic       out_ready,
  input  logic       clear_err,
  output logic [7:0] err_count,
  output logic [4:0] fill
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   PTR_MAX = AW'(DEPTH - 1);
  localparam logic [4:0]      FILL_MAX = 5'(DEPTH);

  // Entry format is {err, data}; illegal codes map to {1, 8'h00}.
  function automatic logic [8:0] decode_code(input logic [3:0] code);
    logic [8:0] res;
    res = 9'h100;
    if (code[3]) begin
      res = 9'h100;
    end else begin
      case (code[2:0])
        3'b000:  res = 9'h080;
        3'b100:  res = 9'h040;
        3'b001:  res = 9'h020;
        3'b101:  res = 9'h010;
        3'b011:  res = 9'h008;
        3'b111:  res = 9'h004;
        3'b010:  res = 9'h002;
        3'b110:  res = 9'h001;
        default: res = 9'h100;
      endcase
    end
    return res;
  endfunction

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    logic [AW-1:0] r;
    if (p == PTR_MAX) begin
      r = '0;
    end else begin
      r = p + AW'(1);
    end
    return r;
  endfunction

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    fill_q, fill_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [8:0]    head_s;
  logic          push_s;
  logic          pop_s;

  // Handshake and head-of-queue presentation.
  always_comb begin
    head_s    = mem_q[rd_ptr_q];
    out_valid = (fill_q != 5'd0);
    pop_s     = out_valid & out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    in_ready  = (fill_q < FILL_MAX) | pop_s;
    push_s    = in_valid & in_ready;
    if (out_valid) begin
      out_data = head_s[7:0];
      out_err  = head_s[8];
    end else begin
      out_data = 8'h00;
      out_err  = 1'b0;
    end
    fill      = fill_q;
    err_count = err_cnt_q;
  end

  // Next-state for pointers, occupancy and the error counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    err_cnt_d = err_cnt_q;
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + 5'd1;
      2'b01:   fill_d = fill_q - 5'd1;
      default: fill_d = fill_q;
    endcase
    if (clear_err) begin
      err_cnt_d = 8'h00;
    end else if (push_s && in_code[3] && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Control state registers; reset discards all queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= 5'd0;
      err_cnt_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written because fill gates them.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= decode_code(in_code);
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  seg_code_decoder_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .fill      (fill)
  );

endmodule

// Protocol invariants for the decoder FIFO, kept apart from the datapath.
module seg_code_decoder_chk #(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  input logic       out_valid,
  input logic       out_ready,
  input logic [7:0] out_data,
  input logic       out_err,
  input logic [4:0] fill
);

  localparam logic [4:0] FILL_MAX = 5'(DEPTH);

  a_fill_bound: assert property (@(posedge clk) fill <= FILL_MAX)
    else $error("fill exceeds DEPTH");

  a_valid_fill: assert property (@(posedge clk) out_valid == (fill != 5'd0))
    else $error("out_valid disagrees with fill");

  a_head_stable: assert property (@(posedge clk)
      (out_valid && !out_ready && !rst) |=> $stable({out_err, out_data}))
    else $error("head changed while stalled");

endmodule
